// File: rtl/sync_4ph_bridge.sv
// sync_4ph_bridge: valid/ready <-> 4-phase bundled-data bridge with synchronised handshakes and sticky timeout flags
module sync_4ph_bridge #(
  parameter int N = 6,
  parameter int SYNC_STAGES = 2,
  parameter int SETUP_CYC = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         tx_req,
  input  logic         tx_ack,
  output logic [N-1:0] tx_data,
  input  logic         rx_req,
  output logic         rx_ack,
  input  logic [N-1:0] rx_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  input  logic         err_clr,
  output logic         tx_err,
  output logic         rx_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(SETUP_CYC + 1);
  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} tx_st_t;
  typedef enum logic [1:0] {WAIT_REQ, HOLD, ACK_HI} rx_st_t;
  tx_st_t tx_st_q, tx_st_d;
  rx_st_t rx_st_q, rx_st_d;
  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d, req_sync_q, req_sync_d;
  logic [SW-1:0] setup_cnt_q, setup_cnt_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [N-1:0] tx_data_q, tx_data_d, out_data_q, out_data_d;
  logic in_ready_q, in_ready_d, tx_req_q, tx_req_d, tx_err_q, tx_err_d;
  logic rx_ack_q, rx_ack_d, out_valid_q, out_valid_d, rx_err_q, rx_err_d;
  logic ack_s, req_s, tx_set, rx_set;
  assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], tx_ack};
  assign req_sync_d = {req_sync_q[SYNC_STAGES-2:0], rx_req};
  assign ack_s = ack_sync_q[SYNC_STAGES-1];
  assign req_s = req_sync_q[SYNC_STAGES-1];
  always_comb begin
    tx_st_d = tx_st_q;
    setup_cnt_d = setup_cnt_q;
    tx_cnt_d = (tx_cnt_q == CW'(TIMEOUT)) ? tx_cnt_q : tx_cnt_q + 1'b1;
    tx_req_d = tx_req_q;
    tx_data_d = tx_data_q;
    in_ready_d = in_ready_q;
    tx_set = 1'b0;
    case (tx_st_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          tx_data_d = in_data;
          in_ready_d = 1'b0;
          setup_cnt_d = '0;
          tx_st_d = SETUP;
        end
      end
      SETUP: begin
        if (setup_cnt_q == SW'(SETUP_CYC - 1)) begin
          tx_req_d = 1'b1;
          tx_cnt_d = '0;
          tx_st_d = REQ_HI;
        end else begin
          setup_cnt_d = setup_cnt_q + 1'b1;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          tx_req_d = 1'b0;
          tx_cnt_d = '0;
          tx_st_d = REQ_LO;
        end else begin
          tx_set = tx_cnt_q == CW'(TIMEOUT - 1);
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          in_ready_d = 1'b1;
          tx_st_d = IDLE;
        end else begin
          tx_set = tx_cnt_q == CW'(TIMEOUT - 1);
        end
      end
      default: tx_st_d = IDLE;
    endcase
    tx_err_d = tx_set | (tx_err_q & ~err_clr);
  end
  always_comb begin
    rx_st_d = rx_st_q;
    rx_cnt_d = (rx_cnt_q == CW'(TIMEOUT)) ? rx_cnt_q : rx_cnt_q + 1'b1;
    rx_ack_d = rx_ack_q;
    out_valid_d = out_valid_q;
    out_data_d = out_data_q;
    rx_set = 1'b0;
    case (rx_st_q)
      WAIT_REQ: begin
        if (req_s) begin
          out_data_d = rx_data;
          out_valid_d = 1'b1;
          rx_st_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          rx_ack_d = 1'b1;
          rx_cnt_d = '0;
          rx_st_d = ACK_HI;
        end
      end
      ACK_HI: begin
        if (!req_s) begin
          rx_ack_d = 1'b0;
          rx_st_d = WAIT_REQ;
        end else begin
          rx_set = rx_cnt_q == CW'(TIMEOUT - 1);
        end
      end
      default: rx_st_d = WAIT_REQ;
    endcase
    rx_err_d = rx_set | (rx_err_q & ~err_clr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st_q <= IDLE;
      rx_st_q <= WAIT_REQ;
      ack_sync_q <= '0;
      req_sync_q <= '0;
      setup_cnt_q <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_data_q <= '0;
      out_data_q <= '0;
      in_ready_q <= 1'b0;
      tx_req_q <= 1'b0;
      tx_err_q <= 1'b0;
      rx_ack_q <= 1'b0;
      out_valid_q <= 1'b0;
      rx_err_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      rx_st_q <= rx_st_d;
      ack_sync_q <= ack_sync_d;
      req_sync_q <= req_sync_d;
      setup_cnt_q <= setup_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_data_q <= tx_data_d;
      out_data_q <= out_data_d;
      in_ready_q <= in_ready_d;
      tx_req_q <= tx_req_d;
      tx_err_q <= tx_err_d;
      rx_ack_q <= rx_ack_d;
      out_valid_q <= out_valid_d;
      rx_err_q <= rx_err_d;
    end
  end
  assign in_ready = in_ready_q;
  assign tx_req = tx_req_q;
  assign tx_data = tx_data_q;
  assign tx_err = tx_err_q;
  assign rx_ack = rx_ack_q;
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign rx_err = rx_err_q;
endmodule
